// File: rtl/seq_mac_pkg.sv
// Shared types and constant helpers for the sequential multiply-accumulate unit.
package seq_mac_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        ACC
    } state_e;

    localparam int LIMIT_W = 128;

    // Counter width able to index 0..value-1, never narrower than one bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // Largest representable accumulator value; callers truncate to their width.
    function automatic logic [LIMIT_W-1:0] sat_hi(input int aw, input bit signed_mode);
        if (signed_mode) begin
            return (LIMIT_W'(1) << (aw - 1)) - LIMIT_W'(1);
        end
        return (LIMIT_W'(1) << aw) - LIMIT_W'(1);
    endfunction

    // Smallest representable accumulator value; the truncated bit pattern is 100..0 when signed.
    function automatic logic [LIMIT_W-1:0] sat_lo(input int aw, input bit signed_mode);
        if (signed_mode) begin
            return LIMIT_W'(1) << (aw - 1);
        end
        return '0;
    endfunction

endpackage

// File: rtl/seq_mult_core.sv
// Iterative radix-2 shift-add multiplier on operand magnitudes; sign returned separately.
module seq_mult_core
    import seq_mac_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   opa,
    input  logic [WIDTH-1:0]   opb,
    output logic [2*WIDTH-1:0] prod,
    output logic               neg,
    output logic               done
);

    localparam int CW = clog2(WIDTH);
    localparam int PW = 2 * WIDTH;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic            busy_q, busy_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] mag_a_q, mag_a_d;
    logic [WIDTH-1:0] mag_b_q, mag_b_d;
    logic [PW-1:0]   prod_q, prod_d;
    logic            neg_q, neg_d;

    // NOTE: every next-state signal takes its current value first so no path leaves it unassigned (no latch).
    always_comb begin
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        mag_a_d = mag_a_q;
        mag_b_d = mag_b_q;
        prod_d  = prod_q;
        neg_d   = neg_q;
        if (start) begin
            // Negating the most-negative value wraps to 2^(WIDTH-1), its exact unsigned magnitude.
            mag_a_d = (SIGNED && opa[WIDTH-1]) ? -opa : opa;
            mag_b_d = (SIGNED && opb[WIDTH-1]) ? -opb : opb;
            neg_d   = SIGNED && (opa[WIDTH-1] ^ opb[WIDTH-1]);
            prod_d  = '0;
            cnt_d   = '0;
            busy_d  = 1'b1;
        end else if (busy_q) begin
            if (mag_b_q[cnt_q]) begin
                prod_d = prod_q + (PW'(mag_a_q) << cnt_q);
            end
            if (cnt_q == LAST) begin
                cnt_d  = '0;
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            mag_a_q <= '0;
            mag_b_q <= '0;
            prod_q  <= '0;
            neg_q   <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            mag_a_q <= mag_a_d;
            mag_b_q <= mag_b_d;
            prod_q  <= prod_d;
            neg_q   <= neg_d;
        end
    end

    assign prod = prod_q;
    assign neg  = neg_q;
    assign done = busy_q && (cnt_q == LAST);

endmodule

// File: rtl/seq_mac_acc.sv
// Handshake-driven sequential MAC: shift-add product folded into a saturating accumulator.
module seq_mac_acc
    import seq_mac_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 2 * WIDTH + 4,
    parameter bit SIGNED    = 1'b0
) (
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     opa,
    input  logic [WIDTH-1:0]     opb,
    input  logic                 acc_clr,
    output logic [ACC_WIDTH-1:0] out,
    output logic                 out_valid,
    output logic                 sat
);

    localparam int SW = ACC_WIDTH + 1;
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = ACC_WIDTH'(sat_hi(ACC_WIDTH, SIGNED));
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = ACC_WIDTH'(sat_lo(ACC_WIDTH, SIGNED));

    state_e               state_q, state_d;
    logic                 acc_clr_q, acc_clr_d;
    logic [ACC_WIDTH-1:0] out_q, out_d;
    logic                 out_valid_q, out_valid_d;
    logic                 sat_q, sat_d;

    logic                 start;
    logic                 done;
    logic                 neg;
    logic [2*WIDTH-1:0]   prod;
    logic [SW-1:0]        base;
    logic [SW-1:0]        term;
    logic [SW-1:0]        sum;

    assign start = in_valid && (state_q == IDLE);

    seq_mult_core #(
        .WIDTH  (WIDTH),
        .SIGNED (SIGNED)
    ) u_core (
        .clk   (clk),
        .clr_n (clr_n),
        .start (start),
        .opa   (opa),
        .opb   (opb),
        .prod  (prod),
        .neg   (neg),
        .done  (done)
    );

    // One guard bit above the accumulator makes overflow visible in the top two bits.
    always_comb begin
        base = acc_clr_q ? '0 : {out_q[ACC_WIDTH-1] & SIGNED, out_q};
        term = SW'(prod);
        if (neg) begin
            term = -term;
        end
        sum = base + term;
    end

    always_comb begin
        state_d     = state_q;
        acc_clr_d   = acc_clr_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        sat_d       = sat_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    acc_clr_d = acc_clr;
                    state_d   = MUL;
                end
            end
            MUL: begin
                if (done) begin
                    state_d = ACC;
                end
            end
            ACC: begin
                state_d     = IDLE;
                out_valid_d = 1'b1;
                if (!SIGNED && sum[SW-1]) begin
                    out_d = ACC_MAX;
                    sat_d = 1'b1;
                end else if (SIGNED && (sum[SW-1] != sum[SW-2])) begin
                    out_d = sum[SW-1] ? ACC_MIN : ACC_MAX;
                    sat_d = 1'b1;
                end else begin
                    out_d = sum[ACC_WIDTH-1:0];
                    if (acc_clr_q) begin
                        sat_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q     <= IDLE;
            acc_clr_q   <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_clr_q   <= acc_clr_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            sat_q       <= sat_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_seq_mac_acc.sv
// Scoreboard bench: unsigned, signed and narrow-accumulator instances share one operand stream.
module tb_seq_mac_acc;

    localparam int W    = 8;
    localparam int AW_U = 20;
    localparam int AW_S = 20;
    localparam int AW_T = 16;

    typedef struct {
        longint acc;
        bit     sat;
    } exp_t;

    logic clk = 1'b0;
    logic clr_n;
    logic in_valid;
    logic [W-1:0] opa;
    logic [W-1:0] opb;
    logic acc_clr;

    logic            u_ready, s_ready, t_ready;
    logic [AW_U-1:0] u_out;
    logic [AW_S-1:0] s_out;
    logic [AW_T-1:0] t_out;
    logic            u_ov, s_ov, t_ov;
    logic            u_sat, s_sat, t_sat;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_acc = 0;
    int u_pulses = 0, s_pulses = 0, t_pulses = 0;
    int last_u = 0, prev_u = 0;
    int acc_cyc = 0;

    longint m_acc [3];
    bit     m_sat [3];
    exp_t   q_u[$];
    exp_t   q_s[$];
    exp_t   q_t[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_mac_acc #(.WIDTH(W), .ACC_WIDTH(AW_U), .SIGNED(1'b0)) u_uns (
        .clk(clk), .clr_n(clr_n), .in_valid(in_valid), .in_ready(u_ready),
        .opa(opa), .opb(opb), .acc_clr(acc_clr),
        .out(u_out), .out_valid(u_ov), .sat(u_sat)
    );

    seq_mac_acc #(.WIDTH(W), .ACC_WIDTH(AW_S), .SIGNED(1'b1)) u_sgn (
        .clk(clk), .clr_n(clr_n), .in_valid(in_valid), .in_ready(s_ready),
        .opa(opa), .opb(opb), .acc_clr(acc_clr),
        .out(s_out), .out_valid(s_ov), .sat(s_sat)
    );

    seq_mac_acc #(.WIDTH(W), .ACC_WIDTH(AW_T), .SIGNED(1'b0)) u_nar (
        .clk(clk), .clr_n(clr_n), .in_valid(in_valid), .in_ready(t_ready),
        .opa(opa), .opb(opb), .acc_clr(acc_clr),
        .out(t_out), .out_valid(t_ov), .sat(t_sat)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference accumulator using plain integer arithmetic and explicit clamping.
    task automatic model_step(input int k, input bit sgn, input int aw,
                              input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic c, output exp_t e);
        longint p, s, hi, lo;
        if (sgn) begin
            p  = longint'($signed(a)) * longint'($signed(b));
            hi = (longint'(1) << (aw - 1)) - 1;
            lo = -(longint'(1) << (aw - 1));
        end else begin
            p  = longint'(a) * longint'(b);
            hi = (longint'(1) << aw) - 1;
            lo = 0;
        end
        s = (c ? longint'(0) : m_acc[k]) + p;
        if (s > hi) begin
            m_acc[k] = hi;
            m_sat[k] = 1'b1;
        end else if (s < lo) begin
            m_acc[k] = lo;
            m_sat[k] = 1'b1;
        end else begin
            m_acc[k] = s;
            if (c) m_sat[k] = 1'b0;
        end
        e.acc = m_acc[k];
        e.sat = m_sat[k];
    endtask

    task automatic push_all(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        exp_t e;
        model_step(0, 1'b0, AW_U, a, b, c, e); q_u.push_back(e);
        model_step(1, 1'b1, AW_S, a, b, c, e); q_s.push_back(e);
        model_step(2, 1'b0, AW_T, a, b, c, e); q_t.push_back(e);
        n_acc++;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_acc[k] = 0;
            m_sat[k] = 1'b0;
        end
        q_u.delete();
        q_s.delete();
        q_t.delete();
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        int n;
        n = 0;
        @(negedge clk);
        while (!u_ready) begin
            n++;
            if (n > 50) begin
                check("send_timeout", 0, 1);
                return;
            end
            @(negedge clk);
        end
        opa      = a;
        opb      = b;
        acc_clr  = c;
        in_valid = 1'b1;
        acc_cyc  = cyc;
        push_all(a, b, c);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((q_u.size() + q_s.size() + q_t.size()) != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) check("drain_timeout", q_u.size() + q_s.size() + q_t.size(), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (clr_n && u_ov) begin
            if (q_u.size() == 0) check("u_unexpected_out_valid", 1, 0);
            else begin
                e = q_u.pop_front();
                check("u_out", longint'(u_out), e.acc);
                check("u_sat", longint'(u_sat), longint'(e.sat));
            end
            u_pulses <= u_pulses + 1;
            prev_u   <= last_u;
            last_u   <= cyc;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (clr_n && s_ov) begin
            if (q_s.size() == 0) check("s_unexpected_out_valid", 1, 0);
            else begin
                e = q_s.pop_front();
                check("s_out", longint'($signed(s_out)), e.acc);
                check("s_sat", longint'(s_sat), longint'(e.sat));
            end
            s_pulses <= s_pulses + 1;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (clr_n && t_ov) begin
            if (q_t.size() == 0) check("t_unexpected_out_valid", 1, 0);
            else begin
                e = q_t.pop_front();
                check("t_out", longint'(t_out), e.acc);
                check("t_sat", longint'(t_sat), longint'(e.sat));
            end
            t_pulses <= t_pulses + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        clr_n    = 1'b0;
        in_valid = 1'b0;
        opa      = '0;
        opb      = '0;
        acc_clr  = 1'b0;
        model_reset();

        repeat (3) @(negedge clk);
        check("rst_out", longint'(u_out), 0);
        check("rst_out_valid", longint'(u_ov), 0);
        check("rst_sat", longint'(u_sat), 0);
        clr_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", longint'(u_ready), 1);

        // Unsigned basics: latency, then back-to-back spacing.
        send(8'd12, 8'd10, 1'b1);
        wait_done();
        check("u_12x10", longint'(u_out), 120);
        check("u_latency", last_u - acc_cyc, 10);
        send(8'd12, 8'd10, 1'b1);
        send(8'd3, 8'd10, 1'b0);
        wait_done();
        check("u_150", longint'(u_out), 150);
        check("u_spacing", last_u - prev_u, 10);

        // Signed products including the most-negative operand.
        send(8'hFD, 8'd5, 1'b1);
        wait_done();
        check("s_m3x5", longint'($signed(s_out)), -15);
        send(8'h80, 8'h80, 1'b0);
        wait_done();
        check("s_acc_16369", longint'($signed(s_out)), 16369);
        send(8'h80, 8'd127, 1'b1);
        wait_done();
        check("s_m128x127", longint'($signed(s_out)), -16256);

        // Saturation on the 16-bit accumulator, then clear.
        send(8'd255, 8'd255, 1'b1);
        wait_done();
        check("t_65025", longint'(t_out), 65025);
        send(8'd255, 8'd255, 1'b0);
        wait_done();
        check("t_sat_val", longint'(t_out), 65535);
        check("t_sat_flag", longint'(t_sat), 1);
        send(8'd1, 8'd1, 1'b1);
        wait_done();
        check("t_clr_val", longint'(t_out), 1);
        check("t_clr_sat", longint'(t_sat), 0);

        // Zero and one corners.
        send(8'd0, 8'd255, 1'b1);
        wait_done();
        check("u_0x255", longint'(u_out), 0);
        send(8'd255, 8'd0, 1'b1);
        wait_done();
        check("u_255x0", longint'(u_out), 0);
        send(8'd1, 8'd255, 1'b1);
        wait_done();
        check("u_1x255", longint'(u_out), 255);
        check("u_corner_sat", longint'(u_sat), 0);

        // in_valid held high with changing operands; only in_ready cycles are accepted.
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            opa      = 8'($urandom);
            opb      = 8'($urandom);
            acc_clr  = ($urandom_range(0, 3) == 0);
            if (u_ready) push_all(opa, opb, acc_clr);
        end
        @(negedge clk);
        in_valid = 1'b0;
        wait_done();
        check("u_pulses_eq_accepts", u_pulses, n_acc);
        check("s_pulses_eq_accepts", s_pulses, n_acc);
        check("t_pulses_eq_accepts", t_pulses, n_acc);

        // Reset in the middle of the multiply phase.
        send(8'd7, 8'd9, 1'b0);
        repeat (2) @(negedge clk);
        clr_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("midrst_out", longint'(u_out), 0);
        check("midrst_out_valid", longint'(u_ov), 0);
        clr_n = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", longint'(u_ready), 1);
        repeat (15) @(negedge clk);
        check("midrst_no_out", longint'(u_out), 0);
        send(8'd2, 8'd2, 1'b0);
        wait_done();
        check("u_after_rst_2x2", longint'(u_out), 4);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
